// File: rtl/blink_pkg.sv
// Shared constants and state encoding for the Blink-128 key loader.
package blink_pkg;

    localparam int WORD_W   = 32;
    localparam int K0_W     = 1024;
    localparam int K1_W     = 510;
    localparam int K0_WORDS = 32;
    localparam int K1_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_K0 = 2'd1,
        LOAD_K1 = 2'd2
    } blink_kl_state_t;

endpackage

// File: rtl/blink_key_loader.sv
// Serial 32-bit key loader assembling the Blink-128 K0/K1 buses.
// Optional build macro BLINK_KEY_ZEROIZE_EN: clear and an accepted start also zero K0/K1.
module blink_key_loader #(
    parameter int WORD_W = blink_pkg::WORD_W,
    parameter int K0_W   = blink_pkg::K0_W,
    parameter int K1_W   = blink_pkg::K1_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic [K0_W-1:0]   K0,
    output logic [K1_W-1:0]   K1,
    output logic              key_valid,
    output logic              busy,
    output logic [7:0]        key_gen,
    output logic              start_err
);
    import blink_pkg::*;

    // Bits of the final K1 word that survive (the rest of the word is dropped).
    localparam int K1_LAST_W = K1_W - WORD_W * (K1_WORDS - 1);

    blink_kl_state_t state_q, state_d;
    logic [4:0]      word_cnt_q, word_cnt_d;
    logic [K0_W-1:0] k0_q, k0_d;
    logic [K1_W-1:0] k1_q, k1_d;
    logic            key_valid_q, key_valid_d;
    logic [7:0]      key_gen_q, key_gen_d;
    logic            start_err_q, start_err_d;

    logic beat;
    logic k0_we;
    logic k1_we;
    logic zeroize;

    assign wr_ready = (state_q != IDLE);
    assign busy     = wr_ready;
    assign beat     = wr_valid && wr_ready;
    // clear wins over any beat in the same cycle
    assign k0_we    = beat && !clear && (state_q == LOAD_K0);
    assign k1_we    = beat && !clear && (state_q == LOAD_K1);

`ifdef BLINK_KEY_ZEROIZE_EN
    assign zeroize = clear || ((state_q == IDLE) && start);
`else
    assign zeroize = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        key_valid_d = key_valid_q;
        key_gen_d   = key_gen_q;
        start_err_d = 1'b0;

        if (clear) begin
            state_d     = IDLE;
            word_cnt_d  = 5'd0;
            key_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = LOAD_K0;
                        word_cnt_d  = 5'd0;
                        key_valid_d = 1'b0;
                    end
                end
                LOAD_K0: begin
                    start_err_d = start;
                    if (beat) begin
                        if (word_cnt_q == 5'(K0_WORDS - 1)) begin
                            state_d    = LOAD_K1;
                            word_cnt_d = 5'd0;
                        end else begin
                            word_cnt_d = word_cnt_q + 5'd1;
                        end
                    end
                end
                LOAD_K1: begin
                    start_err_d = start;
                    if (beat) begin
                        if (word_cnt_q == 5'(K1_WORDS - 1)) begin
                            state_d     = IDLE;
                            word_cnt_d  = 5'd0;
                            key_valid_d = 1'b1;
                            key_gen_d   = key_gen_q + 8'd1;
                        end else begin
                            word_cnt_d = word_cnt_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    word_cnt_d = 5'd0;
                end
            endcase
        end
    end

    // Word-select decode: each key word is rewritten in place only on its own beat.
    for (genvar i = 0; i < K0_WORDS; i++) begin : g_k0_word
        assign k0_d[WORD_W*i +: WORD_W] =
            zeroize ? '0 :
            (k0_we && (word_cnt_q == 5'(i))) ? wr_data : k0_q[WORD_W*i +: WORD_W];
    end

    for (genvar i = 0; i < K1_WORDS; i++) begin : g_k1_word
        if (i < K1_WORDS - 1) begin : g_full
            assign k1_d[WORD_W*i +: WORD_W] =
                zeroize ? '0 :
                (k1_we && (word_cnt_q == 5'(i))) ? wr_data : k1_q[WORD_W*i +: WORD_W];
        end else begin : g_last
            assign k1_d[K1_W-1 -: K1_LAST_W] =
                zeroize ? '0 :
                (k1_we && (word_cnt_q == 5'(i))) ? wr_data[K1_LAST_W-1:0]
                                                 : k1_q[K1_W-1 -: K1_LAST_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_cnt_q  <= 5'd0;
            k0_q        <= '0;
            k1_q        <= '0;
            key_valid_q <= 1'b0;
            key_gen_q   <= 8'd0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            k0_q        <= k0_d;
            k1_q        <= k1_d;
            key_valid_q <= key_valid_d;
            key_gen_q   <= key_gen_d;
            start_err_q <= start_err_d;
        end
    end

    assign K0        = k0_q;
    assign K1        = k1_q;
    assign key_valid = key_valid_q;
    assign key_gen   = key_gen_q;
    assign start_err = start_err_q;

endmodule

// File: tb/tb_blink_key_loader.sv
// Directed bench for blink_key_loader; expectations follow the BLINK_KEY_ZEROIZE_EN build setting.
module tb_blink_key_loader;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          clear;
    logic          wr_valid;
    logic          wr_ready;
    logic [31:0]   wr_data;
    logic [1023:0] K0;
    logic [509:0]  K1;
    logic          key_valid;
    logic          busy;
    logic [7:0]    key_gen;
    logic          start_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1023:0] exp_k0;
    logic [509:0]  exp_k1;

    localparam logic [31:0] SALT_A = 32'h5A5A_0000;
    localparam logic [31:0] SALT_B = 32'h0F0F_0000;

    blink_key_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .K0        (K0),
        .K1        (K1),
        .key_valid (key_valid),
        .busy      (busy),
        .key_gen   (key_gen),
        .start_err (start_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_val(input int idx, input logic [31:0] salt);
        if (idx == 47) return 32'hFFFF_FFEF ^ salt;
        return 32'(idx) ^ salt;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input logic [31:0] salt);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) exp_k0[32*i +: 32] = word_val(i, salt);
        for (int i = 0; i < 15; i++) exp_k1[32*i +: 32] = word_val(32 + i, salt);
        w = word_val(47, salt);
        exp_k1[509:480] = w[29:0];
    endtask

    task automatic run_load(input logic [31:0] salt);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            wr_valid = 1'b1;
            wr_data  = word_val(i, salt);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (K0 !== '0) begin n_fail++; $display("FAIL reset_k0: got %h, expected 0", K0); end
        n_checks++; if (K1 !== '0) begin n_fail++; $display("FAIL reset_k1: got %h, expected 0", K1); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b, expected 0", key_valid); end
        n_checks++; if (key_gen !== 8'd0) begin n_fail++; $display("FAIL reset_key_gen: got %0d, expected 0", key_gen); end
        n_checks++; if (busy !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got busy=%b ready=%b, expected 0 0", busy, wr_ready); end
        n_checks++; if (start_err !== 1'b0) begin n_fail++; $display("FAIL reset_start_err: got %b, expected 0", start_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_load();
        build_exp(32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_rise: got %b, expected 1", wr_ready); end
        for (int i = 0; i < 48; i++) begin
            wr_valid = 1'b1;
            wr_data  = word_val(i, 32'h0);
            if (i == 47) begin
                n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL load_valid_early: got %b, expected 0", key_valid); end
            end
            tick();
        end
        wr_valid = 1'b0;
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL load_key_valid: got %b, expected 1", key_valid); end
        n_checks++; if (key_gen !== 8'd1) begin n_fail++; $display("FAIL load_key_gen: got %0d, expected 1", key_gen); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_busy_end: got %b, expected 0", busy); end
        n_checks++; if (K0[31:0] !== 32'd0) begin n_fail++; $display("FAIL load_k0_w0: got %h, expected 0", K0[31:0]); end
        n_checks++; if (K0[1023:992] !== 32'd31) begin n_fail++; $display("FAIL load_k0_w31: got %h, expected 1f", K0[1023:992]); end
        n_checks++; if (K1[31:0] !== 32'd32) begin n_fail++; $display("FAIL load_k1_w0: got %h, expected 20", K1[31:0]); end
        n_checks++; if (K1[509:480] !== 30'h3FFF_FFEF) begin n_fail++; $display("FAIL load_k1_top: got %h, expected 3fffffef", K1[509:480]); end
        n_checks++; if (K0 !== exp_k0 || K1 !== exp_k1) begin n_fail++; $display("FAIL load_buses: got K0=%h K1=%h", K0, K1); end
    endtask

    task automatic test_stalls();
        int idx = 0;
        int cycles = 0;
        int ready_drop = 0;
        build_exp(32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_drop: got %b, expected 0", key_valid); end
        while (idx < 48 && cycles < 2000) begin
            wr_valid = ($urandom_range(0, 9) < 3);
            wr_data  = wr_valid ? word_val(idx, 32'h0) : 32'hDEAD_BEEF;
            if (wr_ready !== 1'b1) ready_drop++;
            tick();
            if (wr_valid) idx++;
            cycles++;
        end
        wr_valid = 1'b0;
        n_checks++; if (idx != 48) begin n_fail++; $display("FAIL stall_timeout: got %0d beats, expected 48", idx); end
        n_checks++; if (ready_drop != 0) begin n_fail++; $display("FAIL stall_ready: got %0d low cycles, expected 0", ready_drop); end
        n_checks++; if (K0 !== exp_k0 || K1 !== exp_k1) begin n_fail++; $display("FAIL stall_buses: got K0=%h K1=%h", K0, K1); end
        n_checks++; if (key_valid !== 1'b1 || key_gen !== 8'd2) begin n_fail++; $display("FAIL stall_done: got valid=%b gen=%0d, expected 1 2", key_valid, key_gen); end
    endtask

    task automatic test_start_during_load();
        build_exp(SALT_A);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            wr_valid = 1'b1;
            wr_data  = word_val(i, SALT_A);
            start    = (i == 37);
            tick();
            start = 1'b0;
            if (i == 37) begin
                n_checks++; if (start_err !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL start_err_pulse: got err=%b busy=%b, expected 1 1", start_err, busy); end
            end
            if (i == 38) begin
                n_checks++; if (start_err !== 1'b0) begin n_fail++; $display("FAIL start_err_width: got %b, expected 0", start_err); end
            end
        end
        wr_valid = 1'b0;
        n_checks++; if (key_valid !== 1'b1 || key_gen !== 8'd3) begin n_fail++; $display("FAIL start_err_done: got valid=%b gen=%0d, expected 1 3", key_valid, key_gen); end
        n_checks++; if (K0 !== exp_k0 || K1 !== exp_k1) begin n_fail++; $display("FAIL start_err_buses: got K0=%h K1=%h", K0, K1); end
    endtask

    task automatic test_clear_mid_load();
        logic [1023:0] want_k0;
        logic [509:0]  want_k1;
        build_exp(SALT_A);
        want_k0 = exp_k0;
        want_k1 = exp_k1;
        for (int i = 0; i < 10; i++) want_k0[32*i +: 32] = word_val(i, SALT_B);
`ifdef BLINK_KEY_ZEROIZE_EN
        want_k0 = '0;
        want_k1 = '0;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wr_valid = 1'b1;
            wr_data  = word_val(i, SALT_B);
            clear    = (i == 10);
            tick();
        end
        clear    = 1'b0;
        wr_valid = 1'b0;
        n_checks++; if (busy !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got busy=%b ready=%b, expected 0 0", busy, wr_ready); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL clear_key_valid: got %b, expected 0", key_valid); end
        n_checks++; if (key_gen !== 8'd3) begin n_fail++; $display("FAIL clear_key_gen: got %0d, expected 3", key_gen); end
        n_checks++; if (K0 !== want_k0) begin n_fail++; $display("FAIL clear_k0: got %h, expected %h", K0, want_k0); end
        n_checks++; if (K1 !== want_k1) begin n_fail++; $display("FAIL clear_k1: got %h, expected %h", K1, want_k1); end
    endtask

    task automatic test_counter_wrap();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int n = 1; n <= 256; n++) begin
            run_load(32'h0);
            if (n == 255) begin
                n_checks++; if (key_gen !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d, expected 255", key_gen); end
            end
        end
        n_checks++; if (key_gen !== 8'd0 || key_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_zero: got gen=%0d valid=%b, expected 0 1", key_gen, key_valid); end
    endtask

    task automatic test_clear_idle();
        logic [1023:0] want_k0;
        build_exp(32'h0);
        want_k0 = exp_k0;
`ifdef BLINK_KEY_ZEROIZE_EN
        want_k0 = '0;
`endif
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (key_valid !== 1'b0 || key_gen !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL clear_idle_ctrl: got valid=%b gen=%0d busy=%b, expected 0 0 0", key_valid, key_gen, busy); end
        n_checks++; if (K0 !== want_k0) begin n_fail++; $display("FAIL clear_idle_k0: got %h, expected %h", K0, want_k0); end
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 36; i++) begin
            wr_valid = 1'b1;
            wr_data  = word_val(i, SALT_B);
            if (i == 35) begin
                rst_n = 1'b0;
                start = 1'b1;
            end
            tick();
        end
        rst_n    = 1'b1;
        start    = 1'b0;
        wr_valid = 1'b0;
        n_checks++; if (K0 !== '0 || K1 !== '0) begin n_fail++; $display("FAIL rst_mid_buses: got K0=%h K1=%h, expected 0", K0, K1); end
        n_checks++; if (key_valid !== 1'b0 || key_gen !== 8'd0) begin n_fail++; $display("FAIL rst_mid_key: got valid=%b gen=%0d, expected 0 0", key_valid, key_gen); end
        n_checks++; if (busy !== 1'b0 || wr_ready !== 1'b0 || start_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got busy=%b ready=%b err=%b, expected 0 0 0", busy, wr_ready, start_err); end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 32'h0;
        test_reset();
        test_full_load();
        test_stalls();
        test_start_during_load();
        test_clear_mid_load();
        test_counter_wrap();
        test_clear_idle();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blink_key_loader.md
# blink_key_loader

Serial key-material loader upstream of the unrolled Blink-128 core. It accepts 32-bit words over a valid/ready write port and assembles the 1024-bit whitening/round-key bus `K0` and the 510-bit tweakey-hash key `K1`. It holds both buses stable for the combinational cipher and flags completion with `key_valid`. A wrapping generation counter lets downstream logic detect a key change.

## Interface
Parameters:
- `WORD_W`, 32, write-port word width
- `K0_W`, 1024, width of `K0` (32 words)
- `K1_W`, 510, width of `K1` (16 words; top 2 bits of the last word are discarded)

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin a new load (single-cycle pulse).
- `clear`, in, 1: abort or invalidate the key (single-cycle pulse).
- `wr_valid`, in, 1: `wr_data` is valid.
- `wr_ready`, out, 1: loader accepts a word this cycle.
- `wr_data`, in, `WORD_W`: key word.
- `K0`, out, `K0_W`: assembled K0, direct register output.
- `K1`, out, `K1_W`: assembled K1, direct register output.
- `key_valid`, out, 1: `K0`/`K1` hold a complete load.
- `busy`, out, 1: a load is in progress.
- `key_gen`, out, 8: count of completed loads.
- `start_err`, out, 1: one-cycle pulse when `start` is ignored.

## Operation
- The FSM has three states: `IDLE`, `LOAD_K0`, `LOAD_K1`. `word_cnt` is 5 bits.
- **IDLE + `start`:** next state `LOAD_K0`, `word_cnt`=0, `key_valid`←0.
- **Write beat:** a beat occurs when `wr_valid && wr_ready`. `wr_ready` = (state != `IDLE`). `busy` equals `wr_ready`.
- **LOAD_K0 beat:** `K0[32*word_cnt +: 32]`←`wr_data`. At `word_cnt`=31: go to `LOAD_K1` and set `word_cnt`=0. Otherwise increment `word_cnt`.
- **LOAD_K1 beat:** words 0–14 write `K1[32*word_cnt +: 32]`. Word 15 writes `K1[509:480]`←`wr_data[29:0]`; bits 31:30 are dropped. After word 15: state goes to `IDLE`, `key_valid`←1, `key_gen`←`key_gen`+1 (mod 256; 255 wraps to 0).
- **No beat:** `wr_valid` low in a load state stalls with no state change.
- **`start` while loading:** ignored; `start_err` pulses for one cycle; the load continues.
- **`clear`:** takes priority over `start` and over any beat in the same cycle. Next state `IDLE`, `word_cnt`=0, `key_valid`←0, `key_gen` unchanged. `clear` in `IDLE` only drops `key_valid`.
- **Partial data:** key registers are written in place. During a load `K0`/`K1` hold mixed old and new data, and the cipher datapath must qualify use with `key_valid`.
- **Reset:** state `IDLE`, `word_cnt`=0, `K0`=0, `K1`=0, `key_valid`=0, `key_gen`=0, `start_err`=0.
- **Reset during a load** abandons it with the same values.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- `wr_ready` first rises the cycle after `start` is sampled in `IDLE`.
- Minimum load time is 1 + 48 cycles (back-to-back beats). `key_valid` is high in the cycle after the 48th beat.
- `key_gen` updates in the same cycle that `key_valid` rises.
- `start_err` is high exactly in the cycle after the offending `start`.
- `K0`/`K1` are stable whenever `key_valid`=1. The cipher's output is valid after its combinational settle within that same clock period.

## Configuration
- `BLINK_KEY_ZEROIZE_EN` defined: `clear`, and a `start` accepted from `IDLE`, also zero `K0` and `K1` in the next cycle.
- `BLINK_KEY_ZEROIZE_EN` undefined: `K0`/`K1` retain their contents and only `key_valid` is dropped.
- Reset always zeroes `K0`/`K1` in both builds.

## Structure
- Package `blink_pkg` holds:
  - `WORD_W`, `K0_W`, `K1_W`
  - `K0_WORDS`=32, `K1_WORDS`=16
  - the state enum `blink_kl_state_t`
- Single module with no sub-module. The word-select write decode is a generate loop over word indices.

## Test plan
- **Full load:** reset, `start`, 48 back-to-back words with value = index (K0 words 0–31, K1 words 32–47), last word 0xFFFF_FFEF. Expect `K0[31:0]`=0, `K0[1023:992]`=31, `K1[509:480]`=0x3FFF_FFEF, `key_valid`=1 one cycle after beat 48, `key_gen`=1.
- **Stalls:** `wr_valid` random at 30% duty. Expect final buses identical to the full-load case and `wr_ready` continuously high until the last beat.
- **Start during load:** `start` during `LOAD_K1` word 5. Expect `start_err`=1 for one cycle, state unchanged, load completes normally.
- **Clear mid-load:** `clear` asserted in the same cycle as the beat for K0 word 10. Expect word 10 not written, `busy`=0, `key_valid`=0, `key_gen` unchanged. Zeroize build: `K0`=0. Non-zeroize build: words 0–9 retained.
- **Counter wrap:** 256 complete loads. Expect `key_gen` to read 0 after the 256th load and `key_valid`=1.
- **Reset mid-load:** `rst_n` low for one cycle at K1 word 3. Expect all outputs at their reset values the next cycle.
